// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM encoding and helpers.
package ula_pkg;

  localparam logic [4:0] OP_MOVE = 5'b00010;
  localparam logic [4:0] OP_MOVB = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_NOT  = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_SLL  = 5'b01100;
  localparam logic [4:0] OP_SRL  = 5'b01101;
  localparam logic [4:0] OP_LUI  = 5'b01110;
  localparam logic [4:0] OP_SEQ  = 5'b10000;
  localparam logic [4:0] OP_SNE  = 5'b10001;
  localparam logic [4:0] OP_SGT  = 5'b10010;
  localparam logic [4:0] OP_SLT  = 5'b10011;
  localparam logic [4:0] OP_SGE  = 5'b10100;
  localparam logic [4:0] OP_SELT = 5'b10101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_t;

  function automatic logic is_compare(input logic [4:0] op);
    return (op >= OP_SEQ) && (op <= OP_SELT);
  endfunction

endpackage

// File: rtl/ula_iter_muldiv.sv
// Iterative unsigned engine: MSB-first shift-add multiply or restoring divide,
// one result bit per cycle, sharing one accumulator, one shift register and one adder.
module ula_iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] bq;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             mode_q;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;

  // mode_q=0: acc*2 + (msb ? b : 0); mode_q=1: (rem<<1|msb) - b, carry-out means no borrow
  always_comb begin
    x   = {acc[WIDTH-2:0], mode_q & sr[WIDTH-1]};
    y   = mode_q ? ~bq : (sr[WIDTH-1] ? bq : '0);
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, mode_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      sr     <= '0;
      bq     <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      mode_q <= 1'b0;
      last   <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      sr     <= a;
      bq     <= b;
      cnt    <= '0;
      run    <= 1'b1;
      mode_q <= mode;
      last   <= 1'b0;
    end else if (run) begin
      if (mode_q) begin
        acc <= sum[WIDTH] ? sum[WIDTH-1:0] : x;
        sr  <= {sr[WIDTH-2:0], sum[WIDTH]};
      end else begin
        acc <= sum[WIDTH-1:0];
        sr  <= {sr[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        run  <= 1'b0;
        last <= 1'b1;
      end
    end else begin
      last <= 1'b0;
    end
  end

  // Quotient accumulates in the shift register, product in the accumulator
  assign result = mode_q ? sr : acc;

endmodule

// File: rtl/ula_multicycle.sv
// Multi-cycle MIPS ALU: start/busy/done handshake, single-cycle op mux and
// iterative signed multiply/divide with explicit divide-by-zero reporting.
module ula_multicycle
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       opcode_ULA,
  input  logic [WIDTH-1:0] data_src,
  input  logic [WIDTH-1:0] data_tgtImd,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] data_ULA,
  output logic             zero,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   sh_q;
  logic             neg_q;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] eng_res;
  logic             eng_last;
  logic             eng_load;
  logic [WIDTH-1:0] one_res;
  logic             one_flag;
  logic [WIDTH-1:0] fin_res;
  logic             fin_zero;
  logic             fin_dz;

  assign mag_a = data_src[WIDTH-1]    ? -data_src    : data_src;
  assign mag_b = data_tgtImd[WIDTH-1] ? -data_tgtImd : data_tgtImd;

  ula_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .load   (eng_load),
    .mode   (opcode_ULA == OP_DIV),
    .a      (mag_a),
    .b      (mag_b),
    .result (eng_res),
    .last   (eng_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, engine launch and the values written into the output registers
  always_comb begin
    state_next = state;
    eng_load   = 1'b0;
    fin_res    = one_res;
    fin_zero   = one_flag;
    fin_dz     = (op_q == OP_DIV);
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (opcode_ULA == OP_MUL) begin
            state_next = ST_MUL;
            eng_load   = 1'b1;
          end else if (opcode_ULA == OP_DIV && data_tgtImd != '0) begin
            state_next = ST_DIV;
            eng_load   = 1'b1;
          end else begin
            state_next = ST_ONE;
          end
        end
      end
      ST_ONE: state_next = ST_FIN;
      ST_MUL, ST_DIV: begin
        fin_res  = neg_q ? -eng_res : eng_res;
        fin_zero = 1'b0;
        fin_dz   = 1'b0;
        if (eng_last) state_next = ST_FIN;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Single-cycle operations; a divide reaching here has a zero divisor and yields 0
  always_comb begin
    one_res  = '0;
    one_flag = 1'b0;
    case (op_q)
      OP_MOVE: one_res = a_q;
      OP_MOVB: one_res = b_q;
      OP_ADD:  one_res = a_q + b_q;
      OP_SUB:  one_res = a_q - b_q;
      OP_AND:  one_res = a_q & b_q;
      OP_OR:   one_res = a_q | b_q;
      OP_NOT:  one_res = WIDTH'(a_q == '0);
      OP_XOR:  one_res = a_q ^ b_q;
      OP_SLL:  one_res = a_q << sh_q;
      OP_SRL:  one_res = a_q >> sh_q;
      OP_LUI:  one_res = b_q << (WIDTH / 2);
      OP_SEQ:  one_flag = (a_q == b_q);
      OP_SNE:  one_flag = (a_q != b_q);
      OP_SGT:  one_flag = ($signed(a_q) >  $signed(b_q));
      OP_SLT:  one_flag = ($signed(a_q) <  $signed(b_q));
      OP_SGE:  one_flag = ($signed(a_q) >= $signed(b_q));
      OP_SELT: one_flag = ($signed(a_q) <= $signed(b_q));
      default: one_res = '0;
    endcase
    if (is_compare(op_q)) one_res = WIDTH'(one_flag);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sh_q  <= '0;
      neg_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      op_q  <= opcode_ULA;
      a_q   <= data_src;
      b_q   <= data_tgtImd;
      sh_q  <= shamt;
      neg_q <= data_src[WIDTH-1] ^ data_tgtImd[WIDTH-1];
    end
  end

  // Outputs load on entry to FIN so done and the result appear together in that cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_ULA <= '0;
      zero     <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_FIN);
      if (state_next == ST_FIN) begin
        data_ULA <= fin_res;
        zero     <= fin_zero;
        div_zero <= fin_dz;
      end
    end
  end

endmodule

// File: tb/tb_ula_multicycle.sv
// Scoreboard bench for ula_multicycle: directed cases plus a randomized sweep
// against an arithmetic reference model, with latency and handshake checks.
module tb_ula_multicycle;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clock;
  logic           reset;
  logic           start;
  logic [4:0]     opcode_ULA;
  logic [W-1:0]   data_src;
  logic [W-1:0]   data_tgtImd;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   data_ULA;
  logic           zero;
  logic           div_zero;
  logic           busy;
  logic           done;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [4:0] op_tab [19] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                              5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                              5'b01100, 5'b01101, 5'b01110, 5'b10000, 5'b10001,
                              5'b10010, 5'b10011, 5'b10100, 5'b10101};

  ula_multicycle #(.WIDTH(W), .SHW(SHW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .opcode_ULA  (opcode_ULA),
    .data_src    (data_src),
    .data_tgtImd (data_tgtImd),
    .shamt       (shamt),
    .data_ULA    (data_ULA),
    .zero        (zero),
    .div_zero    (div_zero),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: signed integer arithmetic on 64-bit values, truncated to W bits
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [SHW-1:0] sh, output logic [W-1:0] r,
                                output logic z, output logic dz, output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    r = '0; z = 1'b0; dz = 1'b0; lat = 2;
    case (op)
      5'b00010: r = a;
      5'b00011: r = b;
      5'b00100: r = W'(sa + sb);
      5'b00101: r = W'(sa - sb);
      5'b00110: begin r = W'(sa * sb); lat = W + 2; end
      5'b00111: begin
        if (b == '0) dz = 1'b1;
        else begin r = W'(sa / sb); lat = W + 2; end
      end
      5'b01000: r = a & b;
      5'b01001: r = a | b;
      5'b01010: r = (a == '0) ? W'(1) : '0;
      5'b01011: r = a ^ b;
      5'b01100: r = a << sh;
      5'b01101: r = a >> sh;
      5'b01110: r = b << (W / 2);
      5'b10000: z = (sa == sb);
      5'b10001: z = (sa != sb);
      5'b10010: z = (sa >  sb);
      5'b10011: z = (sa <  sb);
      5'b10100: z = (sa >= sb);
      5'b10101: z = (sa <= sb);
      default: ;
    endcase
    if (op >= 5'b10000 && op <= 5'b10101) r = W'(z);
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom_range(0, 40)) - W'(20);
      default: return W'($urandom);
    endcase
  endfunction

  // Waits for IDLE, pulses start for one cycle and pushes the given expectation
  task automatic issue_exp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SHW-1:0] sh, input logic [W-1:0] r, input logic z,
                           input logic dz, input int lat);
    exp_t e;
    int g = 0;
    @(negedge clock);
    while (busy !== 1'b0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (g >= 200) check("idle_timeout", 64'(busy), 64'(0));
    opcode_ULA = op; data_src = a; data_tgtImd = b; shamt = sh; start = 1'b1;
    e.res = r; e.z = z; e.dz = dz; e.lat = lat; e.t0 = cyc;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    opcode_ULA = 5'($urandom); data_src = W'($urandom); data_tgtImd = W'($urandom);
    shamt = SHW'($urandom);
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SHW-1:0] sh);
    logic [W-1:0] r;
    logic z, dz;
    int lat;
    model(op, a, b, sh, r, z, dz, lat);
    issue_exp(op, a, b, sh, r, z, dz, lat);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (g >= 100) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every done pops one expectation and checks result, flags and latency
  always @(negedge clock) begin
    if (!reset && done) begin
      check("busy_at_done", 64'(busy), 64'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_ULA", 64'(data_ULA), 64'(e.res));
        check("zero", 64'(zero), 64'(e.z));
        check("div_zero", 64'(div_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]   op;
    logic [W-1:0] a, b;
    int g;
    reset = 1'b1; start = 1'b0; opcode_ULA = '0; data_src = '0; data_tgtImd = '0; shamt = '0;
    repeat (3) @(negedge clock);
    check("rst_data", 64'(data_ULA), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

    // Directed cases with hand-computed results
    issue_exp(5'b00100, W'(7), -W'(3), '0, W'(4), 1'b0, 1'b0, 2);
    issue_exp(5'b00110, -W'(6), W'(7), '0, -W'(42), 1'b0, 1'b0, W + 2);
    issue_exp(5'b00111, -W'(7), W'(2), '0, -W'(3), 1'b0, 1'b0, W + 2);
    issue_exp(5'b00111, W'(100), W'(0), '0, W'(0), 1'b0, 1'b1, 2);
    issue_exp(5'b10011, -W'(1), W'(0), '0, W'(1), 1'b1, 1'b0, 2);
    issue_exp(5'b01101, 32'h8000_0000, W'(0), 5'd31, W'(1), 1'b0, 1'b0, 2);
    issue_exp(5'b00111, 32'h8000_0000, -W'(1), '0, 32'h8000_0000, 1'b0, 1'b0, W + 2);
    issue_exp(5'b11111, W'(5), W'(9), '0, W'(0), 1'b0, 1'b0, 2);
    drain();

    // start pulsed at cycle 5 of a multiply must be dropped
    issue_exp(5'b00110, W'(3), W'(5), '0, W'(15), 1'b0, 1'b0, W + 2);
    repeat (4) @(negedge clock);
    opcode_ULA = 5'b00100; data_src = W'(1); data_tgtImd = W'(1); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (W + 6) @(negedge clock);

    // start raised during the done cycle is taken one cycle later
    issue_exp(5'b00011, W'(0), W'(77), '0, W'(77), 1'b0, 1'b0, 2);
    g = 0;
    while (done !== 1'b1 && g < 20) begin
      @(negedge clock);
      g++;
    end
    check("done_seen", 64'(done), 64'(1));
    begin
      exp_t e;
      opcode_ULA = 5'b00101; data_src = W'(10); data_tgtImd = W'(3); start = 1'b1;
      e.res = W'(7); e.z = 1'b0; e.dz = 1'b0; e.lat = 2; e.t0 = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    drain();

    // Reset at cycle 10 of a multiply: outputs cleared, no done afterwards
    issue_exp(5'b10100, W'(4), W'(4), '0, W'(1), 1'b1, 1'b0, 2);
    issue_exp(5'b00110, W'(9), W'(9), '0, W'(81), 1'b0, 1'b0, W + 2);
    repeat (9) @(negedge clock);
    check("busy_mid_op", 64'(busy), 64'(1));
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_data", 64'(data_ULA), 64'(0));
    check("abort_zero", 64'(zero), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (W + 8) @(negedge clock);

    // Randomized sweep against the model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
      else op = op_tab[$urandom_range(0, 18)];
      a = rnd_val();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_val();
      issue(op, a, b, SHW'($urandom));
    end
    drain();
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
